// File: rtl/game_ctrl.sv
// Guessing-game controller: seeds the datapath RNG, validates guesses, verdict 3 cycles after acceptance.
// All outputs registered; start/guess_valid are only sampled in states that act on them. Try limit under GAME_TRY_LIMIT_EN.
module game_ctrl #(
    parameter int MIN_SEED  = 8,
    parameter int MAX_TRIES = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       guess_valid,
    input  logic [7:0] guess,
    input  logic       eq,
    output logic       genrand,
    output logic [2:0] cv,
    output logic       ready,
    output logic       bad_guess,
    output logic       win,
    output logic       lose,
    output logic [3:0] tries
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_WAIT, S_CMP, S_LOAD, S_CHK, S_WIN, S_LOSE
    } state_t;

    localparam logic [7:0] MIN_SEED_C = 8'(MIN_SEED);
`ifdef GAME_TRY_LIMIT_EN
    localparam logic [3:0] MAX_TRIES_C = 4'(MAX_TRIES);
`endif

    if (MIN_SEED < 1 || MIN_SEED > 255) begin : g_bad_min_seed
        $error("game_ctrl: MIN_SEED must be 1..255");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
        $error("game_ctrl: MAX_TRIES must be 1..15");
    end

    state_t     state_q;
    logic [7:0] seed_cnt_q;
    logic [7:0] seed_cnt_d;
    logic [7:0] guess_q;
    logic [3:0] tries_d;
    logic       guess_ok;
    logic       try_limit;

    always_comb begin
        seed_cnt_d = (seed_cnt_q == 8'hFF) ? seed_cnt_q : seed_cnt_q + 8'd1;
        tries_d    = (tries == 4'hF) ? tries : tries + 4'd1;
        guess_ok   = (guess != 8'd0) && (guess <= 8'd99);
`ifdef GAME_TRY_LIMIT_EN
        try_limit  = (tries_d == MAX_TRIES_C);
`else
        try_limit  = 1'b0;
`endif
    end

    // Outputs are assigned alongside the transition so they describe the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            seed_cnt_q <= 8'd0;
            guess_q    <= 8'd0;
            genrand    <= 1'b0;
            cv         <= 3'b000;
            ready      <= 1'b0;
            bad_guess  <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
            tries      <= 4'd0;
        end else begin
            genrand   <= 1'b0;
            cv        <= 3'b000;
            ready     <= 1'b0;
            bad_guess <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    seed_cnt_q <= 8'd0;
                    tries      <= 4'd0;
                    win        <= 1'b0;
                    lose       <= 1'b0;
                    if (start) begin
                        state_q <= S_SEED;
                        genrand <= 1'b1;
                    end
                end
                S_SEED: begin
                    seed_cnt_q <= seed_cnt_d;
                    if (!start && seed_cnt_d >= MIN_SEED_C) begin
                        state_q <= S_WAIT;
                        ready   <= 1'b1;
                    end else begin
                        genrand <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (guess_valid && guess_ok) begin
                        guess_q <= guess;
                        state_q <= S_CMP;
                        cv      <= 3'b001;
                    end else begin
                        ready     <= 1'b1;
                        bad_guess <= guess_valid;
                    end
                end
                S_CMP: begin
                    state_q <= S_LOAD;
                    cv      <= 3'b111;
                end
                S_LOAD: begin
                    state_q <= S_CHK;
                    cv      <= 3'b001;
                end
                S_CHK: begin
                    tries <= tries_d;
                    if (eq) begin
                        state_q <= S_WIN;
                        win     <= 1'b1;
                    end else if (try_limit) begin
                        state_q <= S_LOSE;
                        lose    <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                        ready   <= 1'b1;
                    end
                end
                S_WIN, S_LOSE: begin
                    if (start) begin
                        state_q    <= S_SEED;
                        genrand    <= 1'b1;
                        seed_cnt_q <= 8'd0;
                        tries      <= 4'd0;
                        win        <= 1'b0;
                        lose       <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    a_verdict_excl: assert property (@(posedge clk) disable iff (rst) !(win && lose));
    a_guess_range:  assert property (@(posedge clk) disable iff (rst)
                        (state_q == S_CHK) |-> (guess_q != 8'd0 && guess_q <= 8'd99));

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;
    localparam int MIN_SEED  = 8;
    localparam int MAX_TRIES = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       guess_valid = 1'b0;
    logic [7:0] guess = 8'd0;
    logic       eq = 1'b0;
    logic       genrand;
    logic [2:0] cv;
    logic       ready, bad_guess, win, lose;
    logic [3:0] tries;

    game_ctrl #(.MIN_SEED(MIN_SEED), .MAX_TRIES(MAX_TRIES)) dut (
        .clk(clk), .rst(rst), .start(start), .guess_valid(guess_valid),
        .guess(guess), .eq(eq), .genrand(genrand), .cv(cv), .ready(ready),
        .bad_guess(bad_guess), .win(win), .lose(lose), .tries(tries)
    );

    always #5 clk = ~clk;

    logic [11:0] obs;
    assign obs = {genrand, cv, ready, bad_guess, win, lose, tries};

    int tests = 0;
    int fails = 0;
    int exp_tries = 0;

    typedef struct packed {
        logic       win;
        logic       lose;
        logic       ready;
        logic [3:0] tries;
    } verdict_t;
    verdict_t sb_q[$];

    function automatic logic [11:0] ev(logic g, logic [2:0] c, logic r, logic b,
                                       logic w, logic l, logic [3:0] t);
        return {g, c, r, b, w, l, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start high for 'hold' edges; counts genrand cycles until ready; pokes a bad guess mid-seed
    task automatic run_seed(input int hold, output int n, output bit saw_bad);
        n = 0;
        saw_bad = 0;
        start = 1'b1;
        for (int i = 0; i < hold + MIN_SEED + 20; i++) begin
            tick();
            if (i == hold - 1) start = 1'b0;
            if (genrand) n++;
            if (bad_guess) saw_bad = 1;
            guess_valid = (i == 1);
            guess = 8'd150;
            if (ready) break;
        end
        guess_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic do_guess(input logic [7:0] g, input logic e);
        verdict_t v;
        logic     limit;
        int       prev;
        int       w;
        prev = exp_tries;
        exp_tries = (exp_tries == 15) ? 15 : exp_tries + 1;
`ifdef GAME_TRY_LIMIT_EN
        limit = (exp_tries == MAX_TRIES);
`else
        limit = 1'b0;
`endif
        v.win = e;
        v.lose = !e && limit;
        v.ready = !v.win && !v.lose;
        v.tries = 4'(exp_tries);
        sb_q.push_back(v);

        guess = g; guess_valid = 1'b1; eq = !e;
        tick();
        tests++;
        if (obs !== ev(0, 3'b001, 0, 0, 0, 0, 4'(prev))) begin
            fails++; $display("FAIL cmp_cv guess=%0d: got %h want %h", g, obs, ev(0, 3'b001, 0, 0, 0, 0, 4'(prev)));
        end
        guess = 8'd0;
        tick();
        guess_valid = 1'b0;
        tests++;
        if (obs !== ev(0, 3'b111, 0, 0, 0, 0, 4'(prev))) begin
            fails++; $display("FAIL load_cv guess=%0d: got %h want %h", g, obs, ev(0, 3'b111, 0, 0, 0, 0, 4'(prev)));
        end
        eq = e;
        tick();
        tests++;
        if (obs !== ev(0, 3'b001, 0, 0, 0, 0, 4'(prev))) begin
            fails++; $display("FAIL chk_cv guess=%0d: got %h want %h", g, obs, ev(0, 3'b001, 0, 0, 0, 0, 4'(prev)));
        end
        tick();
        w = 0;
        while (!(win || lose || ready) && w < 8) begin
            tick();
            w++;
        end
        tests++;
        if (w != 0) begin
            fails++; $display("FAIL verdict_latency guess=%0d: got %0d extra cycles want 0", g, w);
        end
        v = sb_q.pop_front();
        tests++;
        if (obs !== ev(0, 3'b000, v.ready, 0, v.win, v.lose, v.tries)) begin
            fails++; $display("FAIL verdict guess=%0d: got %h want %h", g, obs, ev(0, 3'b000, v.ready, 0, v.win, v.lose, v.tries));
        end
        eq = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        tests++;
        if (obs !== 12'h000) begin fails++; $display("FAIL reset_async: got %h want 000", obs); end
        repeat (3) tick();
        tests++;
        if (obs !== 12'h000) begin fails++; $display("FAIL reset_held: got %h want 000", obs); end
        rst = 1'b0;
        repeat (2) tick();
        tests++;
        if (obs !== 12'h000) begin fails++; $display("FAIL idle_no_start: got %h want 000", obs); end
        exp_tries = 0;
    endtask

    task automatic test_seed();
        int n;
        bit saw;
        run_seed(3, n, saw);
        tests++;
        if (n != MIN_SEED) begin fails++; $display("FAIL seed_genrand_cycles: got %0d want %0d", n, MIN_SEED); end
        tests++;
        if (obs !== ev(0, 0, 1, 0, 0, 0, 0)) begin fails++; $display("FAIL seed_to_wait: got %h want %h", obs, ev(0, 0, 1, 0, 0, 0, 0)); end
        tests++;
        if (saw) begin fails++; $display("FAIL seed_ignores_guess: got bad_guess=1 want 0"); end
    endtask

    task automatic test_bad_guess();
        logic [7:0] bad [4] = '{8'd0, 8'd100, 8'd150, 8'd255};
        foreach (bad[i]) begin
            guess = bad[i]; guess_valid = 1'b1;
            tick();
            guess_valid = 1'b0;
            tests++;
            if (obs !== ev(0, 0, 1, 1, 0, 0, 4'(exp_tries))) begin
                fails++; $display("FAIL bad_pulse guess=%0d: got %h want %h", bad[i], obs, ev(0, 0, 1, 1, 0, 0, 4'(exp_tries)));
            end
            tick();
            tests++;
            if (obs !== ev(0, 0, 1, 0, 0, 0, 4'(exp_tries))) begin
                fails++; $display("FAIL bad_clear guess=%0d: got %h want %h", bad[i], obs, ev(0, 0, 1, 0, 0, 0, 4'(exp_tries)));
            end
        end
    endtask

    task automatic test_win();
        do_guess(8'd42, 1'b1);
        for (int i = 0; i < 3; i++) begin
            guess = 8'd50; guess_valid = (i == 0);
            tick();
            tests++;
            if (obs !== ev(0, 0, 0, 0, 1, 0, 4'd1)) begin
                fails++; $display("FAIL win_hold cycle=%0d: got %h want %h", i, obs, ev(0, 0, 0, 0, 1, 0, 4'd1));
            end
        end
        guess_valid = 1'b0;
    endtask

    task automatic test_restart();
        int n;
        bit saw;
        start = 1'b1;
        tick();
        exp_tries = 0;
        tests++;
        if (obs !== ev(1, 0, 0, 0, 0, 0, 0)) begin fails++; $display("FAIL restart_from_win: got %h want %h", obs, ev(1, 0, 0, 0, 0, 0, 0)); end
        run_seed(11, n, saw);
        tests++;
        if (n != 11) begin fails++; $display("FAIL long_seed_genrand: got %0d want 11", n); end
        tests++;
        if (obs !== ev(0, 0, 1, 0, 0, 0, 0)) begin fails++; $display("FAIL long_seed_to_wait: got %h want %h", obs, ev(0, 0, 1, 0, 0, 0, 0)); end
        tests++;
        if (saw) begin fails++; $display("FAIL restart_seed_ignores_guess: got bad_guess=1 want 0"); end
    endtask

    task automatic test_misses();
`ifdef GAME_TRY_LIMIT_EN
        int n;
        bit saw;
        for (int k = 0; k < MAX_TRIES; k++)
            do_guess((k == 0) ? 8'd1 : (k == 1) ? 8'd99 : 8'($urandom_range(1, 99)), 1'b0);
        tick();
        tests++;
        if (obs !== ev(0, 0, 0, 0, 0, 1, 4'(MAX_TRIES))) begin
            fails++; $display("FAIL lose_hold: got %h want %h", obs, ev(0, 0, 0, 0, 0, 1, 4'(MAX_TRIES)));
        end
        start = 1'b1;
        tick();
        exp_tries = 0;
        tests++;
        if (obs !== ev(1, 0, 0, 0, 0, 0, 0)) begin fails++; $display("FAIL restart_from_lose: got %h want %h", obs, ev(1, 0, 0, 0, 0, 0, 0)); end
        run_seed(1, n, saw);
        tests++;
        if (!ready) begin fails++; $display("FAIL lose_reseed_ready: got 0 want 1"); end
`else
        for (int k = 0; k < 17; k++)
            do_guess((k == 0) ? 8'd1 : (k == 1) ? 8'd99 : 8'($urandom_range(1, 99)), 1'b0);
`endif
    endtask

    task automatic test_reset_mid_load();
        guess = 8'd10; guess_valid = 1'b1; eq = 1'b1;
        tick();
        guess_valid = 1'b0;
        tick();
        tests++;
        if (obs !== ev(0, 3'b111, 0, 0, 0, 0, 4'(exp_tries))) begin
            fails++; $display("FAIL pre_reset_load: got %h want %h", obs, ev(0, 3'b111, 0, 0, 0, 0, 4'(exp_tries)));
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (obs !== 12'h000) begin fails++; $display("FAIL reset_mid_load: got %h want 000", obs); end
        tick();
        rst = 1'b0;
        eq = 1'b0;
        exp_tries = 0;
        tick();
        tests++;
        if (obs !== 12'h000) begin fails++; $display("FAIL idle_after_reset: got %h want 000", obs); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (obs !== ev(1, 0, 0, 0, 0, 0, 0)) begin fails++; $display("FAIL first_edge_after_reset: got %h want %h", obs, ev(1, 0, 0, 0, 0, 0, 0)); end
    endtask

    initial begin
        test_reset();
        test_seed();
        test_bad_guess();
        test_win();
        test_restart();
        test_misses();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter MIN_SEED, default 8, meaning minimum number of genrand cycles per round (1..255).
REQ-002 SHALL have parameter MAX_TRIES, default 7, meaning guess limit per round (1..15), used only with GAME_TRY_LIMIT_EN.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  level request to begin a round; held high to keep seeding.
REQ-006 SHALL have port guess_valid  input  1  one-cycle strobe, a user guess is present on guess.
REQ-007 SHALL have port guess  input  8  user guess value, unsigned.
REQ-008 SHALL have port eq  input  1  datapath equality flag, guess equals secret.
REQ-009 SHALL have port genrand  output  1  step the datapath random generator.
REQ-010 SHALL have port cv  output  3  datapath control vector {ldLL, ldHL, rangedone}.
REQ-011 SHALL have port ready  output  1  controller accepts a guess this cycle.
REQ-012 SHALL have port bad_guess  output  1  one-cycle pulse, guess rejected as out of range.
REQ-013 SHALL have port win  output  1  round ended with correct guess.
REQ-014 SHALL have port lose  output  1  round ended with tries exhausted.
REQ-015 SHALL have port tries  output  4  guesses accepted this round.

Function
REQ-016 SHALL implement FSM states IDLE, SEED, WAIT, CMP, LOAD, CHK, WIN, LOSE; all outputs registered.
REQ-017 IDLE: all outputs 0; start=1 -> SEED next cycle; seed counter and tries cleared.
REQ-018 SEED: genrand=1 every cycle; seed counter increments, saturates at 255.
REQ-019 SEED -> WAIT only when start=0 and seed counter >= MIN_SEED; start dropping earlier keeps SEED until MIN_SEED reached.
REQ-020 WAIT: ready=1, cv=000; guess_valid=1 with 1<=guess<=99 -> CMP, guess captured internally.
REQ-021 WAIT: guess_valid=1 with guess=0 or guess>99 -> bad_guess=1 for exactly one cycle, stay WAIT, tries unchanged.
REQ-022 guess_valid in any state other than WAIT SHALL be ignored (no pulse, no count).
REQ-023 CMP: cv=001 for one cycle (comparator settles); -> LOAD.
REQ-024 LOAD: cv=111 for one cycle (limits load); -> CHK.
REQ-025 CHK: cv=001; eq sampled; tries increments by 1 (saturate 15); eq=1 -> WIN.
REQ-026 CHK with eq=0 -> WAIT, unless limit reached (REQ-033) -> LOSE.
REQ-027 Guess-to-verdict latency SHALL be 3 cycles after the accepting edge (CMP, LOAD, CHK).
REQ-028 WIN/LOSE: win or lose held at 1, cv=000, tries held; start=1 -> SEED with tries cleared, win/lose cleared.
REQ-029 win and lose SHALL never be 1 simultaneously; genrand SHALL be 0 outside SEED.

Reset
REQ-030 rst=1 SHALL force IDLE immediately, independent of clk, in any state including mid-CMP/LOAD/CHK.
REQ-031 During and after reset: genrand=0, cv=000, ready=0, bad_guess=0, win=0, lose=0, tries=0, seed counter=0.
REQ-032 After rst deasserts, first transition SHALL occur on the next rising clk with start=1.

Configuration
REQ-033 With macro GAME_TRY_LIMIT_EN defined, CHK with eq=0 and updated tries == MAX_TRIES SHALL go to LOSE.
REQ-034 Without GAME_TRY_LIMIT_EN, LOSE SHALL be unreachable, lose tied 0, MAX_TRIES unused; tries saturates at 15.

Verification
REQ-035 rst, start=1 for 3 cycles then 0 -> genrand high for exactly 8 cycles (MIN_SEED=8), then ready=1.
REQ-036 WAIT, guess_valid with guess=150 -> bad_guess 1-cycle pulse, ready stays 1, tries=0.
REQ-037 WAIT, guess=42 strobe, eq=1 in CHK -> cv sequence 001,111,001, win=1 three cycles after acceptance, tries=1.
REQ-038 GAME_TRY_LIMIT_EN, MAX_TRIES=7, seven valid guesses with eq=0 -> lose=1 after 7th CHK, tries=7; without macro -> WAIT, no lose.
REQ-039 rst asserted during LOAD (cv=111) -> cv=000, all outputs 0, state IDLE before next clk edge.
REQ-040 In WIN, start=1 -> genrand=1 next cycle, win=0, tries=0.
